// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot-time byte-stream loader that fills instruction memory and runs the CPU
// Packs bytes little-endian into words, writes them from address 0 while the
// CPU is held in reset, then releases the CPU for RUN_CYCLES enabled cycles
// and freezes it with done raised. Overflowing MEM_WORDS parks in ERROR.
module program_loader #(
    parameter int WORD_BYTES = 4,
    parameter int MEM_WORDS  = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int RUN_CYCLES = 100,
    parameter int CYC_WIDTH  = 32
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             s_valid,
    input  logic [7:0]                       s_data,
    input  logic                             s_last,
    output logic                             s_ready,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [8*WORD_BYTES-1:0]          mem_wdata,
    output logic                             cpu_reset,
    output logic                             cpu_clk_en,
    output logic [$clog2(MEM_WORDS+1)-1:0]   words_loaded,
    output logic [CYC_WIDTH-1:0]             cycles_run,
    output logic                             done,
    output logic                             error
);

    localparam int DW    = 8 * WORD_BYTES;
    localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int WL_W  = $clog2(MEM_WORDS + 1);

    localparam logic [2:0] ST_LOAD  = 3'd0;
    localparam logic [2:0] ST_FLUSH = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    logic [2:0]            r_state;
    logic [IDX_W-1:0]      r_byte_idx;
    logic [DW-1:0]         r_word;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DW-1:0]         r_mem_wdata;
    logic [WL_W-1:0]       r_words;
    logic [CYC_WIDTH-1:0]  r_cycles;

    logic                  w_accept;
    logic                  w_word_last;
    logic                  w_overflow;
    logic [DW-1:0]         w_packed;
    logic [CYC_WIDTH-1:0]  w_cyc_next;
    logic                  w_run_end;

    // Byte acceptance, packing and overflow/run-end detection.
    always_comb begin
        w_accept    = s_valid && (r_state == ST_LOAD);
        w_word_last = (r_byte_idx == IDX_W'(WORD_BYTES - 1));
        // A new word is only started when memory still has room for it.
        w_overflow  = w_accept && (r_words == WL_W'(MEM_WORDS)) && (r_byte_idx == '0);
        w_packed    = r_word | (DW'(s_data) << {r_byte_idx, 3'b000});
        w_cyc_next  = (r_cycles == '1) ? r_cycles : r_cycles + CYC_WIDTH'(1);
        w_run_end   = (w_cyc_next == CYC_WIDTH'(RUN_CYCLES));
    end

    // Load/run state machine with the memory write port and counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_LOAD;
            r_byte_idx  <= '0;
            r_word      <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_words     <= '0;
            r_cycles    <= '0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (w_overflow) begin
                        r_state <= ST_ERROR;
                    end else if (w_accept) begin
                        if (w_word_last || s_last) begin
                            // Upper bytes of r_word are still zero, so a short final word is padded.
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= ADDR_WIDTH'(r_words) * ADDR_WIDTH'(WORD_BYTES);
                            r_mem_wdata <= w_packed;
                            r_words     <= r_words + WL_W'(1);
                            r_word      <= '0;
                            r_byte_idx  <= '0;
                        end else begin
                            r_word      <= w_packed;
                            r_byte_idx  <= r_byte_idx + IDX_W'(1);
                        end
                        if (s_last) begin
                            r_state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    r_state <= (RUN_CYCLES == 0) ? ST_DONE : ST_RUN;
                end
                ST_RUN: begin
                    r_cycles <= w_cyc_next;
                    if (w_run_end) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE:  r_state <= ST_DONE;
                ST_ERROR: r_state <= ST_ERROR;
                default:  r_state <= ST_ERROR;
            endcase
        end
    end

    assign s_ready      = (r_state == ST_LOAD);
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign cpu_reset    = !((r_state == ST_RUN) || (r_state == ST_DONE));
    assign cpu_clk_en   = (r_state == ST_RUN);
    assign words_loaded = r_words;
    assign cycles_run   = r_cycles;
    assign done         = (r_state == ST_DONE);
    assign error        = (r_state == ST_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed scoreboard bench for program_loader
module tb_program_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;

    logic        b_s_ready, b_mem_we, b_cpu_reset, b_cpu_clk_en, b_done, b_error;
    logic [31:0] b_mem_addr, b_mem_wdata, b_cycles_run;
    logic [8:0]  b_words_loaded;

    logic        m_s_ready, m_mem_we, m_cpu_reset, m_cpu_clk_en, m_done, m_error;
    logic [31:0] m_mem_addr, m_mem_wdata, m_cycles_run;
    logic [1:0]  m_words_loaded;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] q_b[$];
    logic [63:0] q_m[$];
    logic [63:0] b_exp, m_exp;

    int          tb_idx;
    int          tb_words;
    logic [31:0] tb_word;

    logic [7:0] img1 [8] = '{8'h13, 8'h05, 8'ha0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};

    always #5 clock = ~clock;

    program_loader #(.WORD_BYTES(4), .MEM_WORDS(256), .ADDR_WIDTH(32), .RUN_CYCLES(100), .CYC_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(b_s_ready), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .cpu_reset(b_cpu_reset), .cpu_clk_en(b_cpu_clk_en), .words_loaded(b_words_loaded),
        .cycles_run(b_cycles_run), .done(b_done), .error(b_error)
    );

    program_loader #(.WORD_BYTES(4), .MEM_WORDS(2), .ADDR_WIDTH(32), .RUN_CYCLES(3), .CYC_WIDTH(32)) dut_small (
        .clock(clock), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(m_s_ready), .mem_we(m_mem_we), .mem_addr(m_mem_addr), .mem_wdata(m_mem_wdata),
        .cpu_reset(m_cpu_reset), .cpu_clk_en(m_cpu_clk_en), .words_loaded(m_words_loaded),
        .cycles_run(m_cycles_run), .done(m_done), .error(m_error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for the large instance: every write must match the next expected word.
    always @(negedge clock) begin
        if (b_mem_we) begin
            n_cmp++;
            assert (q_b.size() > 0) else begin
                n_err++;
                $error("FAIL big_unexpected_write observed addr=%0h data=%0h expected no write", b_mem_addr, b_mem_wdata);
            end
            if (q_b.size() > 0) begin
                b_exp = q_b.pop_front();
                n_cmp++;
                assert ({b_mem_addr, b_mem_wdata} === b_exp) else begin
                    n_err++;
                    $error("FAIL big_write observed=%h_%h expected=%h", b_mem_addr, b_mem_wdata, b_exp);
                end
            end
        end
    end

    // Scoreboard for the two-word instance.
    always @(negedge clock) begin
        if (m_mem_we) begin
            n_cmp++;
            assert (q_m.size() > 0) else begin
                n_err++;
                $error("FAIL small_unexpected_write observed addr=%0h data=%0h expected no write", m_mem_addr, m_mem_wdata);
            end
            if (q_m.size() > 0) begin
                m_exp = q_m.pop_front();
                n_cmp++;
                assert ({m_mem_addr, m_mem_wdata} === m_exp) else begin
                    n_err++;
                    $error("FAIL small_write observed=%h_%h expected=%h", m_mem_addr, m_mem_wdata, m_exp);
                end
            end
        end
    end

    // Drive one byte for one clock; the packing model predicts the write it completes.
    task automatic send_byte(input logic [7:0] b, input logic last);
        s_valid = 1'b1;
        s_data  = b;
        s_last  = last;
        tb_word[8*tb_idx +: 8] = b;
        if (tb_idx == 3 || last) begin
            q_b.push_back({32'(tb_words * 4), tb_word});
            q_m.push_back({32'(tb_words * 4), tb_word});
            tb_words++;
            tb_word = '0;
            tb_idx  = 0;
        end else begin
            tb_idx++;
        end
        @(negedge clock);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset   = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clock);
        chk({tag, "_pending_writes_big"}, 64'(q_b.size()), 64'd0);
        chk({tag, "_pending_writes_small"}, 64'(q_m.size()), 64'd0);
        q_b.delete();
        q_m.delete();
        chk({tag, "_rst_s_ready"}, 64'(b_s_ready), 64'd1);
        chk({tag, "_rst_mem_we"}, 64'(b_mem_we), 64'd0);
        chk({tag, "_rst_cpu_reset"}, 64'(b_cpu_reset), 64'd1);
        chk({tag, "_rst_cpu_clk_en"}, 64'(b_cpu_clk_en), 64'd0);
        chk({tag, "_rst_words"}, 64'(b_words_loaded), 64'd0);
        chk({tag, "_rst_cycles"}, 64'(b_cycles_run), 64'd0);
        chk({tag, "_rst_done_err"}, {62'd0, b_done, b_error}, 64'd0);
        chk({tag, "_rst_small_err"}, 64'(m_error), 64'd0);
        tb_idx   = 0;
        tb_words = 0;
        tb_word  = '0;
        reset    = 1'b0;
    endtask

    // Called at the negedge right after the s_last byte was taken (FLUSH cycle).
    task automatic finish_run(input string tag, input int exp_words);
        int cnt_b;
        int cnt_m;
        cnt_b = 0;
        cnt_m = 0;
        chk({tag, "_flush_words"}, 64'(b_words_loaded), 64'(exp_words));
        chk({tag, "_flush_cpu_reset"}, 64'(b_cpu_reset), 64'd1);
        chk({tag, "_flush_s_ready"}, 64'(b_s_ready), 64'd0);
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (b_done) break;
            if (b_cpu_clk_en) cnt_b++;
            if (m_cpu_clk_en) cnt_m++;
        end
        chk({tag, "_done"}, 64'(b_done), 64'd1);
        chk({tag, "_enabled_cycles"}, 64'(cnt_b), 64'd100);
        chk({tag, "_cycles_run"}, 64'(b_cycles_run), 64'd100);
        chk({tag, "_done_cpu"}, {62'd0, b_cpu_reset, b_cpu_clk_en}, 64'd0);
        chk({tag, "_done_s_ready"}, 64'(b_s_ready), 64'd0);
        chk({tag, "_small_done"}, {62'd0, m_done, m_error}, 64'd2);
        chk({tag, "_small_enabled_cycles"}, 64'(cnt_m), 64'd3);
        chk({tag, "_small_cycles_run"}, 64'(m_cycles_run), 64'd3);
        repeat (3) @(negedge clock);
        chk({tag, "_done_absorbing"}, {62'd0, b_done, b_cpu_clk_en}, 64'd2);
    endtask

    initial begin
        reset    = 1'b1;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        s_last   = 1'b0;
        tb_idx   = 0;
        tb_words = 0;
        tb_word  = '0;
        @(negedge clock);
        chk("init_mem_addr", 64'(b_mem_addr), 64'd0);
        chk("init_mem_wdata", 64'(b_mem_wdata), 64'd0);
        do_reset("s1");

        // Scenario 1: back-to-back image, byte 5 lands in the first write cycle.
        for (int i = 0; i < 8; i++) send_byte(img1[i], i == 7);
        finish_run("s1", 2);

        // Scenario 2: six bytes, last word zero-padded.
        do_reset("s2");
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        chk("s2_flush_words", 64'(b_words_loaded), 64'd2);
        @(negedge clock);
        chk("s2_run_cpu", {62'd0, b_cpu_reset, b_cpu_clk_en}, 64'd1);

        // Scenario 3: overflow of the two-word instance, no s_last.
        do_reset("s3");
        for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b0);
        chk("s3_small_error", 64'(m_error), 64'd1);
        chk("s3_small_s_ready", 64'(m_s_ready), 64'd0);
        chk("s3_small_cpu", {62'd0, m_cpu_reset, m_cpu_clk_en}, 64'd2);
        chk("s3_small_words", 64'(m_words_loaded), 64'd2);
        chk("s3_big_no_error", {62'd0, b_error, b_s_ready}, 64'd1);
        chk("s3_big_words", 64'(b_words_loaded), 64'd2);
        repeat (4) @(negedge clock);
        chk("s3_small_error_absorbing", {62'd0, m_error, m_done}, 64'd2);
        chk("s3_big_partial_held", 64'(b_words_loaded), 64'd2);

        // Scenario 4: idle gaps between every byte.
        do_reset("s4");
        for (int i = 0; i < 8; i++) begin
            if (i != 0) repeat ($urandom_range(1, 3)) @(negedge clock);
            send_byte(img1[i], i == 7);
        end
        finish_run("s4", 2);

        // Scenario 5: reset after three bytes discards them, then the full image.
        do_reset("s5a");
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hBE, 1'b0);
        do_reset("s5b");
        for (int i = 0; i < 8; i++) send_byte(img1[i], i == 7);
        finish_run("s5", 2);

        chk("end_pending_big", 64'(q_b.size()), 64'd0);
        chk("end_pending_small", 64'(q_m.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
